// File: rtl/ram32x8_arbiter_pkg.sv
// Shared types and reset constants for the two-port Ram32x8 access engine.
package ram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              grant;
    } txn_t;

    localparam state_t            RST_STATE      = IDLE;
    localparam txn_t              RST_TXN        = '0;
    localparam logic [DATA_W-1:0] RST_RDATA      = '0;
    localparam logic              RST_LAST_GRANT = 1'b1;

endpackage

// File: rtl/ram32x8_arbiter_if.sv
// Requester and RAM-pin bundle; the tristate on the data bus lives outside.
interface ram32x8_arbiter_if #(
    parameter int AddrWidth = 5,
    parameter int DataWidth = 8
);

    logic                 Req0Valid;
    logic                 Req0Write;
    logic [AddrWidth-1:0] Req0Addr;
    logic [DataWidth-1:0] Req0WData;
    logic                 Req0Ready;
    logic                 Req0RValid;
    logic [DataWidth-1:0] Req0RData;

    logic                 Req1Valid;
    logic                 Req1Write;
    logic [AddrWidth-1:0] Req1Addr;
    logic [DataWidth-1:0] Req1WData;
    logic                 Req1Ready;
    logic                 Req1RValid;
    logic [DataWidth-1:0] Req1RData;

    logic                 Busy;
    logic                 RamCe;
    logic                 RamRd;
    logic                 RamWr;
    logic [AddrWidth-1:0] RamAddr;
    logic [DataWidth-1:0] RamDataOut;
    logic                 RamDataOe;
    logic [DataWidth-1:0] RamDataIn;

    modport slave (
        input  Req0Valid, Req0Write, Req0Addr, Req0WData,
        input  Req1Valid, Req1Write, Req1Addr, Req1WData,
        input  RamDataIn,
        output Req0Ready, Req0RValid, Req0RData,
        output Req1Ready, Req1RValid, Req1RData,
        output Busy, RamCe, RamRd, RamWr,
        output RamAddr, RamDataOut, RamDataOe
    );

    modport master (
        output Req0Valid, Req0Write, Req0Addr, Req0WData,
        output Req1Valid, Req1Write, Req1Addr, Req1WData,
        output RamDataIn,
        input  Req0Ready, Req0RValid, Req0RData,
        input  Req1Ready, Req1RValid, Req1RData,
        input  Busy, RamCe, RamRd, RamWr,
        input  RamAddr, RamDataOut, RamDataOe
    );

endinterface

// File: rtl/ram32x8_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the port not granted last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       idx
);

    logic last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= RST_LAST_GRANT;
        end else if (|gnt) begin
            last_grant <= idx;
        end
    end

    always_comb begin
        idx = 1'b0;
        gnt = 2'b00;
        if (valid == 2'b11) begin
            idx = ~last_grant;
        end else begin
            idx = valid[1];
        end
        if (enable && (|valid)) begin
            gnt = idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram32x8_arbiter.sv
// Sequences one async SRAM through setup/strobe/hold for two requesters.
module ram32x8_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AddrWidth    = ADDR_W,
    parameter int DataWidth    = DATA_W,
    parameter int StrobeCycles = 2
) (
    input logic              Clk,
    input logic              Reset,
    ram32x8_arbiter_if.slave bus
);

    localparam int CW = $clog2(StrobeCycles + 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(StrobeCycles);

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        cnt;
    txn_t                 txn;
    logic [DataWidth-1:0] rdata0;
    logic [DataWidth-1:0] rdata1;
    logic [1:0]           valid;
    logic [1:0]           gnt;
    logic                 gidx;
    logic                 accept;
    logic                 last;
    logic                 idle;

    assign valid  = {bus.Req1Valid, bus.Req0Valid};
    assign idle   = (state == IDLE);
    assign accept = |gnt;
    assign last   = (cnt == CW'(1));

    rr_arb2 u_arb (
        .clk    (Clk),
        .rst    (Reset),
        .valid  (valid),
        .enable (idle),
        .gnt    (gnt),
        .idx    (gidx)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (accept) state_nx = SETUP;
            SETUP:  state_nx = STROBE;
            STROBE: if (last) state_nx = HOLD;
            HOLD:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter is loaded in SETUP so it is ready for the first STROBE cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= STROBE_LOAD;
        end else if (state == STROBE) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            txn <= RST_TXN;
        end else if (accept) begin
            txn.write <= gidx ? bus.Req1Write : bus.Req0Write;
            txn.addr  <= ADDR_W'(gidx ? bus.Req1Addr : bus.Req0Addr);
            txn.wdata <= DATA_W'(gidx ? bus.Req1WData : bus.Req0WData);
            txn.grant <= gidx;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata0 <= DataWidth'(RST_RDATA);
            rdata1 <= DataWidth'(RST_RDATA);
        end else if (state == STROBE && last && !txn.write) begin
            if (txn.grant) begin
                rdata1 <= bus.RamDataIn;
            end else begin
                rdata0 <= bus.RamDataIn;
            end
        end
    end

    assign bus.Req0Ready  = gnt[0];
    assign bus.Req1Ready  = gnt[1];
    assign bus.Req0RValid = (state == HOLD) && !txn.write && !txn.grant;
    assign bus.Req1RValid = (state == HOLD) && !txn.write && txn.grant;
    assign bus.Req0RData  = rdata0;
    assign bus.Req1RData  = rdata1;

    assign bus.Busy       = !idle;
    assign bus.RamCe      = idle;
    assign bus.RamRd      = (state == STROBE) && !txn.write;
    assign bus.RamWr      = (state == STROBE) && txn.write;
    assign bus.RamDataOe  = !idle && txn.write;
    assign bus.RamAddr    = AddrWidth'(txn.addr);
    assign bus.RamDataOut = DataWidth'(txn.wdata);

endmodule

// File: tb/tb_ram32x8_arbiter.sv
// Directed bench: two DUTs (StrobeCycles 2 and 1) with a small RAM model.
module tb_ram32x8_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ram32x8_arbiter_if #(.AddrWidth(5), .DataWidth(8)) b0 ();
    ram32x8_arbiter_if #(.AddrWidth(5), .DataWidth(8)) b1 ();

    ram32x8_arbiter #(.AddrWidth(5), .DataWidth(8), .StrobeCycles(2)) u0 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (b0.slave)
    );

    ram32x8_arbiter #(.AddrWidth(5), .DataWidth(8), .StrobeCycles(1)) u1 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (b1.slave)
    );

    logic [7:0] mem [32];

    always @(posedge clk) begin
        if (b0.RamWr) mem[b0.RamAddr] <= b0.RamDataOut;
    end
    assign b0.RamDataIn = mem[b0.RamAddr];
    assign b1.RamDataIn = 8'hFF;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic       prev_ce = 1'b1;
    logic [4:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_wr_overlap0", b0.RamRd & b0.RamWr, 0);
            chk("rd_wr_overlap1", b1.RamRd & b1.RamWr, 0);
            chk("oe_not_write", b0.RamDataOe & (b0.RamCe | b0.RamRd), 0);
            chk("wr_without_oe", b0.RamWr & ~b0.RamDataOe, 0);
            chk("u1_req0_rvalid", b1.Req0RValid, 0);
            if (!prev_ce && !b0.RamCe) chk("addr_stable", b0.RamAddr, prev_addr);
        end
        prev_ce   = b0.RamCe;
        prev_addr = b0.RamAddr;
    end

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [4:0] a, input logic [7:0] d);
        if (p == 0) begin
            b0.Req0Valid = v; b0.Req0Write = w; b0.Req0Addr = a; b0.Req0WData = d;
        end else begin
            b0.Req1Valid = v; b0.Req1Write = w; b0.Req1Addr = a; b0.Req1WData = d;
        end
    endtask

    task automatic wait_ready(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((p == 0) ? b0.Req0Ready : b0.Req1Ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("ready%0d_seen", p), ok, 1);
    endtask

    // Runs one request on u0; returns at the negedge of its HOLD cycle.
    task automatic txn(input int p, input logic w, input logic [4:0] a,
                       input logic [7:0] d, input logic [7:0] exp);
        bit ok;
        int wr_hi = 0;
        set_req(p, 1'b1, w, a, d);
        wait_ready(p, ok);
        chk("ready_excl", b0.Req0Ready & b0.Req1Ready, 0);
        @(posedge clk); #1;
        set_req(p, 1'b0, w, a, d);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (b0.RamWr) wr_hi++;
            chk($sformatf("rvalid_p%0d_n%0d", p, n),
                (p == 0) ? b0.Req0RValid : b0.Req1RValid, (!w && n == 4));
            chk($sformatf("rvalid_other_n%0d", n),
                (p == 0) ? b0.Req1RValid : b0.Req0RValid, 0);
            chk($sformatf("addr_n%0d", n), b0.RamAddr, a);
            chk($sformatf("oe_n%0d", n), b0.RamDataOe, w);
            chk($sformatf("busy_n%0d", n), b0.Busy, 1);
            if (w) chk($sformatf("wdata_n%0d", n), b0.RamDataOut, d);
        end
        if (w) chk("wr_cycles", wr_hi, 2);
        else chk("rdata", (p == 0) ? b0.Req0RData : b0.Req1RData, exp);
    endtask

    initial begin
        bit ok;
        int gap;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        b1.Req0Valid = 0; b1.Req0Write = 0; b1.Req0Addr = 0; b1.Req0WData = 0;
        b1.Req1Valid = 0; b1.Req1Write = 0; b1.Req1Addr = 0; b1.Req1WData = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", b0.RamCe, 1);
        chk("rst_rd_wr_oe", {b0.RamRd, b0.RamWr, b0.RamDataOe}, 0);
        chk("rst_addr", b0.RamAddr, 0);
        chk("rst_dout", b0.RamDataOut, 0);
        chk("rst_ready", {b0.Req0Ready, b0.Req1Ready}, 0);
        chk("rst_rvalid", {b0.Req0RValid, b0.Req1RValid}, 0);
        chk("rst_rdata", {b0.Req0RData, b0.Req1RData}, 0);
        chk("rst_busy", b0.Busy, 0);
        chk("rst_u1_ce", b1.RamCe, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Write then read back through port 0.
        txn(0, 1'b1, 5'd5, 8'hA5, 8'h00);
        txn(0, 1'b0, 5'd5, 8'h00, 8'hA5);

        // Port 1 arrives mid-STROBE of a port-0 write and must wait.
        set_req(0, 1'b1, 1'b1, 5'd9, 8'h3C);
        wait_ready(0, ok);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 5'd9, 8'h3C);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 5'd9, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("r1_wait_%0d", i), b0.Req1Ready, 0);
        end
        @(negedge clk);
        chk("r1_first_idle", b0.Req1Ready, 1);
        chk("r1_idle_busy", b0.Busy, 0);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 5'd9, 8'h00);
        repeat (4) @(negedge clk);
        chk("r1_rvalid", b0.Req1RValid, 1);
        chk("r1_rdata", b0.Req1RData, 8'h3C);

        // Reset during the second STROBE cycle of a read.
        set_req(0, 1'b1, 1'b0, 5'd5, 8'h00);
        wait_ready(0, ok);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 5'd5, 8'h00);
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_rd", b0.RamRd, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ce", b0.RamCe, 1);
        chk("mid_rst_rd", b0.RamRd, 0);
        chk("mid_rst_busy", b0.Busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_rvalid_%0d", i), b0.Req0RValid, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        txn(0, 1'b0, 5'd5, 8'h00, 8'hA5);

        // Fresh reset, then both ports stream writes.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 5'd10, 8'h11);
        set_req(1, 1'b1, 1'b1, 5'd20, 8'h22);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            gap = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                gap++;
                if (b0.Req0Ready | b0.Req1Ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk($sformatf("arb_seen_%0d", k), ok, 1);
            chk($sformatf("arb_excl_%0d", k), b0.Req0Ready & b0.Req1Ready, 0);
            chk($sformatf("arb_grant_%0d", k), b0.Req1Ready, k % 2);
            if (k > 0) chk($sformatf("arb_gap_%0d", k), gap, 5);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 5'd10, 8'h11);
        set_req(1, 1'b0, 1'b1, 5'd20, 8'h22);
        repeat (6) @(negedge clk);
        chk("arb_mem10", mem[10], 8'h11);
        chk("arb_mem20", mem[20], 8'h22);
        chk("arb_idle", b0.Busy, 0);

        // StrobeCycles=1 instance: port-1 read of the top address.
        @(posedge clk); #1;
        b1.Req1Valid = 1'b1; b1.Req1Write = 1'b0; b1.Req1Addr = 5'd31;
        @(negedge clk);
        chk("s1_ready", b1.Req1Ready, 1);
        @(posedge clk); #1 b1.Req1Valid = 1'b0;
        @(negedge clk);
        chk("s1_setup_ce", b1.RamCe, 0);
        chk("s1_setup_rd", b1.RamRd, 0);
        chk("s1_setup_addr", b1.RamAddr, 31);
        @(negedge clk);
        chk("s1_strobe_rd", b1.RamRd, 1);
        chk("s1_strobe_busy", b1.Busy, 1);
        @(negedge clk);
        chk("s1_hold_rd", b1.RamRd, 0);
        chk("s1_hold_rvalid", b1.Req1RValid, 1);
        chk("s1_hold_rdata", b1.Req1RData, 8'hFF);
        chk("s1_hold_ce", b1.RamCe, 0);
        @(negedge clk);
        chk("s1_done_busy", b1.Busy, 0);
        chk("s1_done_ce", b1.RamCe, 1);
        chk("s1_done_rvalid", b1.Req1RValid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
